// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller of the VGA clock.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SET    = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_e;

    localparam int unsigned BCD_W    = 4;
    localparam int unsigned HR_WRAP  = 23;
    localparam int unsigned MIN_WRAP = 59;

    localparam int unsigned DEF_TONE_DIV   = 25000;
    localparam int unsigned DEF_RING_SEC   = 60;
    localparam int unsigned DEF_SNOOZE_SEC = 300;

endpackage

// File: rtl/bcd_hhmm_counter.sv
// Alarm HH:MM register pair with independent BCD hour/minute increments.
module bcd_hhmm_counter
    import alarm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_hr,
    input  logic             inc_min,
    output logic [BCD_W-1:0] hr_10s,
    output logic [BCD_W-1:0] hr_1s,
    output logic [BCD_W-1:0] min_10s,
    output logic [BCD_W-1:0] min_1s
);

    logic [BCD_W-1:0] hr_10s_q, hr_1s_q, min_10s_q, min_1s_q;
    logic [BCD_W-1:0] hr_10s_d, hr_1s_d, min_10s_d, min_1s_d;

    always_comb begin
        hr_10s_d  = hr_10s_q;
        hr_1s_d   = hr_1s_q;
        min_10s_d = min_10s_q;
        min_1s_d  = min_1s_q;
        if (inc_hr) begin
            if (hr_10s_q == BCD_W'(HR_WRAP / 10) && hr_1s_q == BCD_W'(HR_WRAP % 10)) begin
                hr_10s_d = '0;
                hr_1s_d  = '0;
            end else if (hr_1s_q == BCD_W'(9)) begin
                hr_10s_d = hr_10s_q + BCD_W'(1);
                hr_1s_d  = '0;
            end else begin
                hr_1s_d  = hr_1s_q + BCD_W'(1);
            end
        end
        // Minute wrap never carries into the hour.
        if (inc_min) begin
            if (min_1s_q == BCD_W'(9)) begin
                min_1s_d  = '0;
                min_10s_d = (min_10s_q == BCD_W'(MIN_WRAP / 10)) ? '0 : min_10s_q + BCD_W'(1);
            end else begin
                min_1s_d  = min_1s_q + BCD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hr_10s_q  <= '0;
            hr_1s_q   <= '0;
            min_10s_q <= '0;
            min_1s_q  <= '0;
        end else begin
            hr_10s_q  <= hr_10s_d;
            hr_1s_q   <= hr_1s_d;
            min_10s_q <= min_10s_d;
            min_1s_q  <= min_1s_d;
        end
    end

    assign hr_10s  = hr_10s_q;
    assign hr_1s   = hr_1s_q;
    assign min_10s = min_10s_q;
    assign min_1s  = min_1s_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm controller: button arbitration, alarm trigger, RING/SNOOZE FSM and buzzer tone.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV   = DEF_TONE_DIV,
    parameter int unsigned RING_SEC   = DEF_RING_SEC,
    parameter int unsigned SNOOZE_SEC = DEF_SNOOZE_SEC
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             tick_1Hz,
    input  logic             btn_set,
    input  logic             btn_hr,
    input  logic             btn_min,
    input  logic             btn_snooze,
    input  logic             alarm_en,
    input  logic [BCD_W-1:0] hr_10s,
    input  logic [BCD_W-1:0] hr_1s,
    input  logic [BCD_W-1:0] min_10s,
    input  logic [BCD_W-1:0] min_1s,
    input  logic [BCD_W-1:0] sec_10s,
    input  logic [BCD_W-1:0] sec_1s,
    output logic [BCD_W-1:0] alarm_hr_10s,
    output logic [BCD_W-1:0] alarm_hr_1s,
    output logic [BCD_W-1:0] alarm_min_10s,
    output logic [BCD_W-1:0] alarm_min_1s,
    output logic             tick_hr_o,
    output logic             tick_min_o,
    output logic             show_alarm,
    output logic             ringing,
    output logic             buzzer
);

    localparam int unsigned TONE_W = $clog2(TONE_DIV + 1);
    localparam int unsigned RING_W = $clog2(RING_SEC + 1);
    localparam int unsigned SNZ_W  = $clog2(SNOOZE_SEC + 1);

    state_e            state_q, state_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic              match_prev_q, match_prev_d;
    logic              buzzer_q, buzzer_d;
    logic              ringing_q, ringing_d;
    logic              show_alarm_q, show_alarm_d;
    logic              tick_hr_q, tick_hr_d;
    logic              tick_min_q, tick_min_d;
    logic              inc_hr_c, inc_min_c;
    logic              match_c, trigger_c;

    bcd_hhmm_counter u_alarm_time (
        .clk     (clk_100MHz),
        .rst     (reset),
        .inc_hr  (inc_hr_c),
        .inc_min (inc_min_c),
        .hr_10s  (alarm_hr_10s),
        .hr_1s   (alarm_hr_1s),
        .min_10s (alarm_min_10s),
        .min_1s  (alarm_min_1s)
    );

    assign match_c = alarm_en
                   && hr_10s  == alarm_hr_10s  && hr_1s  == alarm_hr_1s
                   && min_10s == alarm_min_10s && min_1s == alarm_min_1s
                   && sec_10s == '0 && sec_1s == '0;
    assign trigger_c = match_c && !match_prev_q;

    always_comb begin
        state_d      = state_q;
        tone_cnt_d   = tone_cnt_q;
        ring_cnt_d   = ring_cnt_q;
        snz_cnt_d    = snz_cnt_q;
        buzzer_d     = buzzer_q;
        match_prev_d = match_c;
        tick_hr_d    = 1'b0;
        tick_min_d   = 1'b0;
        inc_hr_c     = 1'b0;
        inc_min_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_hr_d  = btn_hr;
                tick_min_d = btn_min;
                if (btn_set)        state_d = ST_SET;
                else if (trigger_c) state_d = ST_RING;
            end
            ST_SET: begin
                inc_hr_c  = btn_hr;
                inc_min_c = btn_min;
                if (btn_set) state_d = ST_IDLE;
            end
            ST_RING: begin
                if (!alarm_en || btn_set) begin
                    state_d = ST_IDLE;
                end else if (btn_snooze) begin
                    state_d = ST_SNOOZE;
                end else if (tick_1Hz) begin
                    if (ring_cnt_q == RING_W'(RING_SEC - 1)) state_d = ST_IDLE;
                    else ring_cnt_d = ring_cnt_q + RING_W'(1);
                end
            end
            ST_SNOOZE: begin
                tick_hr_d  = btn_hr;
                tick_min_d = btn_min;
                if (!alarm_en || btn_set) begin
                    state_d = ST_IDLE;
                end else if (tick_1Hz) begin
                    if (snz_cnt_q <= SNZ_W'(1)) state_d = ST_RING;
                    snz_cnt_d = (snz_cnt_q == '0) ? '0 : snz_cnt_q - SNZ_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every entry into RING restarts the ring timer and the tone from a low phase.
        if (state_d == ST_RING) begin
            if (state_q != ST_RING) begin
                ring_cnt_d = '0;
                tone_cnt_d = '0;
                buzzer_d   = 1'b0;
            end else if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
                tone_cnt_d = '0;
                buzzer_d   = ~buzzer_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
            end
        end else begin
            tone_cnt_d = '0;
            buzzer_d   = 1'b0;
        end

        if (state_d == ST_SNOOZE && state_q != ST_SNOOZE) snz_cnt_d = SNZ_W'(SNOOZE_SEC);

        ringing_d    = (state_d == ST_RING);
        show_alarm_d = (state_d == ST_SET);
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tone_cnt_q   <= '0;
            ring_cnt_q   <= '0;
            snz_cnt_q    <= '0;
            match_prev_q <= 1'b0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            show_alarm_q <= 1'b0;
            tick_hr_q    <= 1'b0;
            tick_min_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tone_cnt_q   <= tone_cnt_d;
            ring_cnt_q   <= ring_cnt_d;
            snz_cnt_q    <= snz_cnt_d;
            match_prev_q <= match_prev_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            show_alarm_q <= show_alarm_d;
            tick_hr_q    <= tick_hr_d;
            tick_min_q   <= tick_min_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign ringing    = ringing_q;
    assign show_alarm = show_alarm_q;
    assign tick_hr_o  = tick_hr_q;
    assign tick_min_o = tick_min_q;

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Controls the alarm feature of the VGA digital clock.
- Owns the alarm HH:MM registers and arbitrates the shared hour/minute buttons between alarm setting and timekeeper setting.
- Detects the alarm time, runs the RING/SNOOZE state machine and drives the buzzer square wave.
- Drives the display select, so the pixel generator shows alarm time while in SET mode.

Parameters:
- TONE_DIV, 25000, clk_100MHz cycles per buzzer half-period (2 kHz tone).
- RING_SEC, 60, seconds of ringing before auto-dismiss.
- SNOOZE_SEC, 300, seconds of silence after a snooze before re-ringing.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1Hz  in  1  one-cycle pulse per second from the timekeeper
- btn_set  in  1  debounced one-cycle pulse; enter/leave SET, or dismiss while ringing
- btn_hr  in  1  debounced one-cycle pulse; hour increment
- btn_min  in  1  debounced one-cycle pulse; minute increment
- btn_snooze  in  1  debounced one-cycle pulse
- alarm_en  in  1  level; alarm armed
- hr_10s, hr_1s, min_10s, min_1s, sec_10s, sec_1s  in  4 each  current BCD time
- alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  out  4 each  alarm BCD time
- tick_hr_o, tick_min_o  out  1  hour/minute increment pulses forwarded to the timekeeper
- show_alarm  out  1  display select; 1 = show alarm time with seconds 00
- ringing  out  1  high in RING
- buzzer  out  1  tone output

Behaviour:
- Reset (async, immediate) sets:
  - state IDLE
  - alarm time 00:00
  - all outputs 0
  - all counters 0
  - match_prev 0
- All outputs are registered.
- States: IDLE, SET, RING, SNOOZE.
- IDLE:
  - btn_set -> SET.
  - btn_hr / btn_min are forwarded as tick_hr_o / tick_min_o one cycle later.
  - Alarm trigger -> RING.
- SET:
  - show_alarm = 1.
  - tick_hr_o and tick_min_o are held at 0, so buttons never reach the timekeeper.
  - btn_hr increments alarm hour 00..23, wrapping 23 -> 00.
  - btn_min increments alarm minute 00..59, wrapping 59 -> 00, with no carry into the hour.
  - btn_hr and btn_min in the same cycle are both applied.
  - btn_set -> IDLE.
  - The alarm trigger is suppressed while in SET.
- Trigger:
  - match = alarm_en & (hr, min equal to alarm) & sec_10s == 0 & sec_1s == 0.
  - match_prev is registered each cycle.
  - The trigger is the rising edge (match & ~match_prev), evaluated only in IDLE.
  - Latency: state = RING and ringing = 1 on the cycle after the edge.
  - A match held for the full second triggers exactly once.
- RING:
  - On entry, ring_cnt and tone_cnt are cleared and buzzer = 0.
  - tone_cnt counts 0..TONE_DIV-1; buzzer toggles at the wrap, so the first rising edge occurs TONE_DIV cycles after entry.
  - ring_cnt increments on tick_1Hz; at RING_SEC -> IDLE.
  - Exit priority within one cycle: reset > alarm_en = 0 or btn_set (dismiss, -> IDLE) > btn_snooze (-> SNOOZE) > ring_cnt timeout.
  - Buttons are not forwarded in RING.
- SNOOZE:
  - Entry loads snz_cnt = SNOOZE_SEC.
  - snz_cnt decrements on tick_1Hz; at 1 -> 0 the state -> RING, with counters re-cleared.
  - alarm_en = 0 or btn_set -> IDLE.
  - btn_snooze in SNOOZE is ignored.
  - btn_hr / btn_min are forwarded.
  - Time matches are ignored.
- Buzzer and ringing are forced to 0 in every state except RING. They fall on the cycle the state leaves RING.
- Counter widths: $clog2(N+1) of their limits; no overflow is possible.
- Changing the alarm time never disturbs the current time digits.

Decomposition:
- alarm_pkg holds:
  - state encoding (2-bit)
  - BCD limits (HR_WRAP = 23, MIN_WRAP = 59)
  - default parameter constants
- One sub-module, bcd_hhmm_counter:
  - alarm HH:MM registers with independent hour/minute increment enables and BCD wrap.
  - Same async reset to 00:00.
- The FSM, counters, tone generator and button arbitration stay in alarm_sequencer.

Test Plan:
All scenarios use TONE_DIV = 4, RING_SEC = 3, SNOOZE_SEC = 2.
- Set wrap: btn_set, then 24 btn_hr pulses and 61 btn_min pulses -> alarm 00:01; tick_hr_o / tick_min_o stay 0 throughout; show_alarm = 1 until the second btn_set.
- Arbitration: in IDLE, a btn_min pulse -> tick_min_o pulses for exactly one cycle, one cycle later; alarm digits unchanged.
- Trigger and timeout: alarm 07:30, alarm_en = 1, time driven to 07:30:00 and held for 100 cycles -> ringing rises one cycle after, buzzer toggles every 4 cycles; 3 tick_1Hz -> IDLE, no retrigger while 07:30:00 is held.
- Snooze: while ringing, btn_snooze -> buzzer 0 next cycle; after 2 tick_1Hz -> RING again with ring_cnt restarted.
- Priority: btn_set and btn_snooze in the same RING cycle -> IDLE, not SNOOZE; alarm_en dropped in SNOOZE -> IDLE.
- Reset mid-ring: assert reset asynchronously between clock edges -> buzzer, ringing and show_alarm go 0 immediately; alarm returns to 00:00.
